// File: rtl/spram_stream_reader.sv
// Streams LEN words read from a single-port RAM starting at BASE, with a skid FIFO absorbing read latency.
// Optional feature macro: SPRAM_RD_ABORT_EN adds an abort input that cancels the running command.
module spram_stream_reader #(
  parameter int DWIDTH     = 128,
  parameter int AWIDTH     = 2,
  parameter int RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [AWIDTH-1:0] base,
  input  logic [AWIDTH:0]   len,
`ifdef SPRAM_RD_ABORT_EN
  input  logic              abort,
`endif
  output logic              busy,
  output logic              done,
  output logic [AWIDTH-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [DWIDTH-1:0] mem_q,
  output logic [DWIDTH-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last
);
  localparam int FDEPTH = RD_LATENCY + 2;
  localparam int CW     = $clog2(FDEPTH + 1);
  localparam int PW     = $clog2(FDEPTH);
  localparam int FSLOTS = 1 << PW;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

  // Stream handshake: a beat transfers on any rising clk edge where m_valid && m_ready;
  // while m_valid && !m_ready, m_data and m_last hold their values.
  state_t            state_q;
  logic [AWIDTH-1:0] addr_q;
  logic [AWIDTH:0]   rem_q;
  logic [AWIDTH:0]   len_q;
  logic [AWIDTH:0]   beat_q;
  logic              done_q;
  logic [CW-1:0]     count_q;
  logic [CW-1:0]     inflight;
  logic [PW-1:0]     wr_ptr_q;
  logic [PW-1:0]     rd_ptr_q;
  logic [DWIDTH-1:0] fifo_q [FSLOTS];
  logic              issue;
  logic              room;
  logic              flush;
  logic              fifo_push;
  logic              fifo_pop;
  logic              drain_done;

`ifdef SPRAM_RD_ABORT_EN
  assign flush = abort && (state_q != S_IDLE);
`else
  assign flush = 1'b0;
`endif

  // Outstanding reads plus buffered words never exceed the FIFO depth, so a push always finds a slot.
  assign room  = ({1'b0, count_q} + {1'b0, inflight}) < (CW + 1)'(FDEPTH);
  assign issue = (state_q == S_ISSUE) && room && !flush;

  if (RD_LATENCY == 0) begin : g_comb
    assign fifo_push = issue;
    assign inflight  = '0;
  end else begin : g_pipe
    logic [RD_LATENCY-1:0] pipe_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        pipe_q <= '0;
      end else if (flush) begin
        pipe_q <= '0;
      end else begin
        pipe_q <= (pipe_q << 1) | RD_LATENCY'(issue);
      end
    end

    always_comb begin
      inflight = '0;
      for (int i = 0; i < RD_LATENCY; i++) begin
        inflight = inflight + CW'(pipe_q[i]);
      end
    end

    assign fifo_push = pipe_q[RD_LATENCY-1];
  end

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FDEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign m_valid  = (count_q != '0);
  assign fifo_pop = m_valid && m_ready;
  assign m_data   = m_valid ? fifo_q[rd_ptr_q] : '0;
  assign m_last   = m_valid && (beat_q == len_q - 1'b1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < FSLOTS; i++) begin
        fifo_q[i] <= '0;
      end
    end else if (flush) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (fifo_push) begin
        fifo_q[wr_ptr_q] <= mem_q;
        wr_ptr_q         <= ptr_inc(wr_ptr_q);
      end
      if (fifo_pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      if (fifo_push && !fifo_pop) begin
        count_q <= count_q + 1'b1;
      end else if (!fifo_push && fifo_pop) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

  // The final beat may pop in the same cycle the drain check runs, so done lands right after it.
  assign drain_done = (inflight == '0) &&
                      ((count_q == '0) || ((count_q == CW'(1)) && fifo_pop));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      len_q   <= '0;
      beat_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (fifo_pop) begin
        beat_q <= beat_q + 1'b1;
      end
      if (flush) begin
        state_q <= S_DRAIN;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start) begin
              if (len == '0) begin
                done_q <= 1'b1;
              end else begin
                len_q   <= len;
                rem_q   <= len;
                addr_q  <= base;
                beat_q  <= '0;
                state_q <= S_ISSUE;
              end
            end
          end
          S_ISSUE: begin
            if (issue) begin
              addr_q <= addr_q + 1'b1;
              rem_q  <= rem_q - 1'b1;
              if (rem_q == (AWIDTH + 1)'(1)) begin
                state_q <= S_DRAIN;
              end
            end
          end
          S_DRAIN: begin
            if (drain_done) begin
              done_q  <= 1'b1;
              state_q <= S_IDLE;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;
  assign mem_addr = addr_q;
  assign mem_rd   = issue;

endmodule
